// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and constant helpers for the serial chunk adder.
// Holds the FSM state encoding and the chunk counter width calculation.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // At least one counter bit, even when a single chunk spans the whole word.
  function automatic int cnt_w(input int chunks);
    return (clog2(chunks) < 1) ? 1 : clog2(chunks);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk_adder.sv
// Combinational K-bit ripple adder used once per cycle by the serial adder.
// c_msb exposes the carry into bit K-1 so the caller can derive signed overflow.
module chunk_adder #(
  parameter int K = 8
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         ci,
  output logic [K-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [K:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < K; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[K];
  assign c_msb = c[K-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Handshaked signed adder that sums two N-bit operands K bits per cycle, LSB first.
// Produces SUM, Cout and signed overflow after N/K cycles of ADD.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] SUM,
  output logic         Cout,
  output logic         OF,
  output logic         busy
);

  localparam int            CHUNKS = N / K;
  localparam int            CW     = cnt_w(CHUNKS);
  localparam logic [CW-1:0] LAST   = CW'(CHUNKS - 1);
  localparam logic [N-1:0]  MASK   = N'({K{1'b1}});

  generate
    if (K < 1 || (N % K) != 0) begin : g_bad_width
      $error("serial_chunk_adder: N must be a positive multiple of K");
    end
  endgenerate

  state_t        state;
  logic [N-1:0]  a_q, b_q;
  logic          carry_q;
  logic [CW-1:0] cnt;

  logic [K-1:0]  a_ch, b_ch, s_ch;
  logic          co_ch, cmsb_ch;
  int            sh;
  logic [N-1:0]  sum_next;

  // Shifts rather than variable part-selects keep the chunk index width-neutral.
  assign sh       = int'(cnt) * K;
  assign a_ch     = K'(a_q >> sh);
  assign b_ch     = K'(b_q >> sh);
  assign sum_next = (SUM & ~(MASK << sh)) | (N'(s_ch) << sh);

  chunk_adder #(.K(K)) u_chunk (
    .a     (a_ch),
    .b     (b_ch),
    .ci    (carry_q),
    .s     (s_ch),
    .co    (co_ch),
    .c_msb (cmsb_ch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      SUM       <= '0;
      Cout      <= 1'b0;
      OF        <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in1;
            b_q      <= in2;
            carry_q  <= cin;
            SUM      <= '0;
            Cout     <= 1'b0;
            OF       <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          SUM     <= sum_next;
          carry_q <= co_ch;
          if (cnt == LAST) begin
            Cout      <= co_ch;
            OF        <= cmsb_ch ^ co_ch;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          cnt       <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three instances (K=8, 32, 4) share stimulus and
// are checked against an arithmetic reference for result, latency and handshake.
module tb_serial_chunk_adder;

  localparam int N = 32;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0] in1 = '0, in2 = '0;
  logic cin = 1'b0;

  logic [ND-1:0] rdy, ov, co, of, bz;
  logic [N-1:0]  sm [ND];

  int checks = 0;
  int errors = 0;
  int exp_lat [ND] = '{4, 1, 8};

  always #5 clk = ~clk;

  serial_chunk_adder #(.N(N), .K(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in1(in1), .in2(in2),
    .cin(cin), .out_valid(ov[0]), .out_ready(out_ready), .SUM(sm[0]), .Cout(co[0]),
    .OF(of[0]), .busy(bz[0]));
  serial_chunk_adder #(.N(N), .K(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in1(in1), .in2(in2),
    .cin(cin), .out_valid(ov[1]), .out_ready(out_ready), .SUM(sm[1]), .Cout(co[1]),
    .OF(of[1]), .busy(bz[1]));
  serial_chunk_adder #(.N(N), .K(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in1(in1), .in2(in2),
    .cin(cin), .out_valid(ov[2]), .out_ready(out_ready), .SUM(sm[2]), .Cout(co[2]),
    .OF(of[2]), .busy(bz[2]));

  task automatic check(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Reference: plain N+1 bit arithmetic and sign rule.
  task automatic ref_add(input logic [N-1:0] a, b, input logic c,
                         output logic [N-1:0] s, output logic cout, output logic ovf);
    logic [N:0] t;
    t    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    s    = t[N-1:0];
    cout = t[N];
    ovf  = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endtask

  task automatic run_op(input logic [N-1:0] a, b, input logic c, input bit bp);
    logic [N-1:0] es; logic ec, eo;
    int lat [ND];
    ref_add(a, b, c, es, ec, eo);
    @(negedge clk);
    for (int i = 0; i < ND; i++) check("in_ready_idle", i, rdy[i], 1);
    in1 = a; in2 = b; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; cin = 1'($urandom);
    lat = '{0, 0, 0};
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < ND; i++) if (ov[i] && lat[i] == 0) lat[i] = k;
      if (k == 1) check("busy_add", 0, bz[0], 1);
      if (ov == '1) break;
    end
    for (int i = 0; i < ND; i++) check("latency", i, lat[i], exp_lat[i]);
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = ~in_valid; in1 = $urandom;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < ND; i++) begin
          check("bp_sum", i, sm[i], es);
          check("bp_cout", i, co[i], ec);
          check("bp_of", i, of[i], eo);
          check("bp_in_ready", i, rdy[i], 0);
          check("bp_out_valid", i, ov[i], 1);
        end
      end
      in_valid = 1'b0;
    end
    for (int i = 0; i < ND; i++) begin
      check("sum", i, sm[i], es);
      check("cout", i, co[i], ec);
      check("of", i, of[i], eo);
      check("busy_done", i, bz[i], 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check("ov_cleared", i, ov[i], 0);
      check("in_ready_back", i, rdy[i], 1);
      check("sum_kept", i, sm[i], es);
    end
  endtask

  logic [N-1:0] va [6] = '{32'h40000000, 32'h80000001, 32'hFFFFFFEA, 32'h00000001, 32'h00FFFFFF, 32'hFFFFFFFF};
  logic [N-1:0] vb [6] = '{32'h40000000, 32'h80000001, 32'hFFFFFFEA, 32'h80000000, 32'h00000001, 32'h00000000};
  logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #12;
    for (int i = 0; i < ND; i++) begin
      check("rst_sum", i, sm[i], 0);
      check("rst_cout", i, co[i], 0);
      check("rst_of", i, of[i], 0);
      check("rst_ov", i, ov[i], 0);
      check("rst_busy", i, bz[i], 0);
      check("rst_in_ready", i, rdy[i], 1);
    end
    @(negedge clk); rst = 1'b0;

    // out_ready with nothing pending must not produce a result.
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < ND; i++) check("idle_out_ready", i, ov[i], 0);

    for (int v = 0; v < 6; v++) run_op(va[v], vb[v], vc[v], 1'b0);
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);
    for (int r = 0; r < 20; r++) run_op($urandom, $urandom, 1'($urandom), r % 5 == 0);

    // Abort in the second cycle of ADD.
    @(negedge clk);
    in1 = 32'h11111111; in2 = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    for (int i = 0; i < ND; i++) begin
      check("abort_ov", i, ov[i], 0);
      check("abort_sum", i, sm[i], 0);
      check("abort_in_ready", i, rdy[i], 1);
      check("abort_busy", i, bz[i], 0);
    end
    @(negedge clk); rst = 1'b0;
    run_op(32'h00000016, 32'h00000016, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
